// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if: bundle of the arbitration signals shared between the bus
// masters and the arbiter.
//   master modport : the bus side; drives hbusreq/hlock, the owner's
//                    htrans/hburst and the slave-side hready/hresp, and
//                    observes the grant/ownership outputs.
//   slave modport  : the arbiter side; mirror image of the above.
// Handshake: hready is the only qualifier. An edge with hready=1 accepts the
// current address phase, and with it all arbitration state advances; an edge
// with hready=0 is a wait state and nothing moves.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0]             htrans;
  logic [2:0]             hburst;
  logic                   hready;
  logic                   hresp;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [1:0]             hmaster;
  logic [1:0]             hmaster_data;
  logic                   hmastlock;

  modport master (
    output hbusreq, hlock, htrans, hburst, hready, hresp,
    input  hgrant, hmaster, hmaster_data, hmastlock
  );

  modport slave (
    input  hbusreq, hlock, htrans, hburst, hready, hresp,
    output hgrant, hmaster, hmaster_data, hmastlock
  );
endinterface

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin arbiter for a single-layer AHB bus with up to four
// masters. Grants are one-hot and change only at legal transfer boundaries:
// never during a wait state, never inside a locked sequence, and never before
// the second-to-last beat of a fixed-length burst has been accepted.
// Ports:
//   hclk, hreset : clock and asynchronous active-high reset
//   bus          : ahb_arbiter_if.slave (requests, owner transfer info,
//                  hready/hresp in; hgrant/hmaster/hmaster_data/hmastlock out)
//   dbg_cnt      : beats of the owner's fixed burst still to be issued
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic         hclk,
  input  logic         hreset,
  ahb_arbiter_if.slave bus,
  output logic [3:0]   dbg_cnt
);

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [3:0]             cnt;
  logic [3:0]             cnt_next;
  logic [1:0]             grant_idx;
  logic [NUM_MASTERS-1:0] next_grant;
  logic                   found;
  logic                   hold;

  assign dbg_cnt = cnt;

  // Index of the currently granted master (hgrant is always one-hot).
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (bus.hgrant[i]) grant_idx = 2'(i);
    end
  end

  // Remaining-beat tracking for fixed-length bursts. The NONSEQ load is
  // beats-1 because the NONSEQ itself is the first beat. IDLE ends any burst.
  always_comb begin
    cnt_next = cnt;
    if (bus.hresp) begin
      cnt_next = 4'd0;
    end else begin
      case (bus.htrans)
        HTRANS_NONSEQ: begin
          case (bus.hburst[2:1])
            2'b01:   cnt_next = 4'd3;
            2'b10:   cnt_next = 4'd7;
            2'b11:   cnt_next = 4'd15;
            default: cnt_next = 4'd0;
          endcase
        end
        HTRANS_SEQ:  cnt_next = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        HTRANS_BUSY: cnt_next = cnt;
        HTRANS_IDLE: cnt_next = 4'd0;
        default:     cnt_next = cnt;
      endcase
    end
  end

  // Releasing at cnt_next <= 1 hands the grant over one beat early so the
  // next owner's NONSEQ follows the last beat with no dead cycle.
  assign hold = bus.hlock[grant_idx] | (cnt_next > 4'd1);

  // Round-robin search begins just after the granted master and ends on it,
  // so two persistent requesters alternate on consecutive accepted beats.
  always_comb begin
    next_grant = DEFAULT_GRANT;
    found      = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!found && bus.hbusreq[(int'(grant_idx) + k) % NUM_MASTERS]) begin
        found      = 1'b1;
        next_grant = '0;
        next_grant[(int'(grant_idx) + k) % NUM_MASTERS] = 1'b1;
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      bus.hgrant       <= DEFAULT_GRANT;
      bus.hmaster      <= 2'(DEFAULT_MASTER);
      bus.hmaster_data <= 2'(DEFAULT_MASTER);
      bus.hmastlock    <= 1'b0;
      cnt              <= 4'd0;
    end else if (bus.hready) begin
      bus.hmaster      <= grant_idx;
      bus.hmaster_data <= bus.hmaster;
      bus.hmastlock    <= bus.hlock[grant_idx];
      cnt              <= cnt_next;
      if (!hold) bus.hgrant <= next_grant;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
module tb_ahb_arbiter;

  logic       hclk;
  logic       hreset;
  logic [3:0] dbg_cnt;
  int         checks;
  int         errors;

  ahb_arbiter_if #(.NUM_MASTERS(4)) bus ();

  ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .hclk    (hclk),
    .hreset  (hreset),
    .bus     (bus.slave),
    .dbg_cnt (dbg_cnt)
  );

  // Clock / reset
  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  // Driver helpers
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge hclk);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lock,
                       input logic [1:0] trans, input logic [2:0] burst,
                       input logic ready, input logic resp);
    bus.hbusreq = req;
    bus.hlock   = lock;
    bus.htrans  = trans;
    bus.hburst  = burst;
    bus.hready  = ready;
    bus.hresp   = resp;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] m,
                           input logic [1:0] md, input logic ml);
    check({tag, ".hgrant"},       32'(bus.hgrant),       32'(g));
    check({tag, ".hmaster"},      32'(bus.hmaster),      32'(m));
    check({tag, ".hmaster_data"}, 32'(bus.hmaster_data), 32'(md));
    check({tag, ".hmastlock"},    32'(bus.hmastlock),    32'(ml));
  endtask

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, INCR4 = 3'd3, INCR8 = 3'd5, INCR16 = 3'd7;

  initial begin
    checks = 0;
    errors = 0;
    hreset = 1'b1;
    drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    #12;
    hreset = 1'b0;

    // Reset state and idle bus: default master keeps the grant.
    check_all("reset", 4'b0001, 2'd0, 2'd0, 1'b0);
    check("reset.cnt", 32'(dbg_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_all("idle", 4'b0001, 2'd0, 2'd0, 1'b0);
    end

    // Two requesters alternate on SINGLE transfers; hmaster/hmaster_data lag.
    drive(4'b0110, 4'b0000, NONSEQ, SINGLE, 1'b1, 1'b0);
    tick(1); check_all("rr1", 4'b0010, 2'd0, 2'd0, 1'b0);
    tick(1); check_all("rr2", 4'b0100, 2'd1, 2'd0, 1'b0);
    tick(1); check_all("rr3", 4'b0010, 2'd2, 2'd1, 1'b0);
    tick(1); check_all("rr4", 4'b0100, 2'd1, 2'd2, 1'b0);

    // Hand the bus to master 1, then an INCR4 with two wait states on beat 2.
    drive(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    tick(2);
    check("own1.hgrant", 32'(bus.hgrant), 32'b0010);
    check("own1.hmaster", 32'(bus.hmaster), 32'd1);
    drive(4'b1010, 4'b0000, NONSEQ, INCR4, 1'b1, 1'b0);
    tick(1);
    check("incr4.b1.hgrant", 32'(bus.hgrant), 32'b0010);
    check("incr4.b1.cnt", 32'(dbg_cnt), 32'd3);
    drive(4'b1010, 4'b0000, SEQ, INCR4, 1'b0, 1'b0);
    tick(2);
    check("incr4.wait.hgrant", 32'(bus.hgrant), 32'b0010);
    check("incr4.wait.cnt", 32'(dbg_cnt), 32'd3);
    check("incr4.wait.hmaster", 32'(bus.hmaster), 32'd1);
    bus.hready = 1'b1;
    tick(1);
    check("incr4.b2.hgrant", 32'(bus.hgrant), 32'b0010);
    check("incr4.b2.cnt", 32'(dbg_cnt), 32'd2);
    tick(1);
    check("incr4.b3.hgrant", 32'(bus.hgrant), 32'b1000);
    check("incr4.b3.hmaster", 32'(bus.hmaster), 32'd1);
    bus.hbusreq = 4'b1000;
    tick(1);
    check("incr4.b4.hgrant", 32'(bus.hgrant), 32'b1000);
    check("incr4.b4.hmaster", 32'(bus.hmaster), 32'd3);
    check("incr4.b4.cnt", 32'(dbg_cnt), 32'd0);

    // Locked sequence by master 2 against all-request competition.
    drive(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    tick(1);
    check("lock.pre.hgrant", 32'(bus.hgrant), 32'b0100);
    drive(4'b1111, 4'b0100, NONSEQ, SINGLE, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("lock.hgrant", 32'(bus.hgrant), 32'b0100);
      check("lock.hmastlock", 32'(bus.hmastlock), 32'd1);
    end
    bus.hlock = 4'b0000;
    tick(1);
    check("unlock.hgrant", 32'(bus.hgrant), 32'b1000);
    check("unlock.hmastlock", 32'(bus.hmastlock), 32'd0);

    // Master 0 INCR8 cut short by an ERROR response on beat 3.
    drive(4'b0001, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    tick(2);
    check("own0.hmaster", 32'(bus.hmaster), 32'd0);
    drive(4'b0011, 4'b0000, NONSEQ, INCR8, 1'b1, 1'b0);
    tick(1);
    check("incr8.b1.cnt", 32'(dbg_cnt), 32'd7);
    bus.htrans = SEQ;
    tick(1);
    check("incr8.b2.hgrant", 32'(bus.hgrant), 32'b0001);
    check("incr8.b2.cnt", 32'(dbg_cnt), 32'd6);
    bus.hresp = 1'b1;
    tick(1);
    check("err.hgrant", 32'(bus.hgrant), 32'b0010);
    check("err.cnt", 32'(dbg_cnt), 32'd0);

    // Asynchronous reset in the middle of an INCR16.
    drive(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    tick(1);
    drive(4'b0011, 4'b0000, NONSEQ, INCR16, 1'b1, 1'b0);
    tick(1);
    check("incr16.b1.cnt", 32'(dbg_cnt), 32'd15);
    bus.htrans = SEQ;
    tick(1);
    check("incr16.b2.cnt", 32'(dbg_cnt), 32'd14);
    check("incr16.b2.hmaster", 32'(bus.hmaster), 32'd1);
    #2;
    hreset = 1'b1;
    #1;
    check_all("async_rst", 4'b0001, 2'd0, 2'd0, 1'b0);
    check("async_rst.cnt", 32'(dbg_cnt), 32'd0);
    hreset = 1'b0;
    bus.htrans = IDLE;
    tick(1);
    check("post_rst.hgrant", 32'(bus.hgrant), 32'b0010);
    check("post_rst.hmaster", 32'(bus.hmaster), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
